wm_phase_sequencer: RTL

Phase sequencer for the washing-machine controller. It takes a programme request (mode 1/2/3) and steps through the fill, soak, wash, rinse and spin phases. Each phase lasts a fixed number of timer ticks. A tick is derived from the main clock by a prescaler. The block drives the phase-operation and water-intake outputs, pauses while the lid is open, and aborts on cancel. The top-level controller handles coin and ready logic and issues `start` to this block.

---
 rtl/wm_pkg.sv | 48 ++++
 rtl/wm_tick_prescaler.sv | 35 +++
 rtl/wm_phase_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/wm_pkg.sv
// Shared state codes, programme modes and phase-ordering helper for the
// washing-machine controller and its phase sequencer.
package wm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_SOAK  = 3'd2,
        ST_WASH  = 3'd3,
        ST_RINSE = 3'd4,
        ST_SPIN  = 3'd5,
        ST_FILL  = 3'd6,
        ST_DONE  = 3'd7
    } wm_state_e;

    localparam logic [1:0] MODE_NONE  = 2'd0;
    localparam logic [1:0] MODE_FULL  = 2'd1;
    localparam logic [1:0] MODE_WASH  = 2'd2;
    localparam logic [1:0] MODE_RINSE = 2'd3;

    // Phase that follows a completed phase; the second FILL always leads to RINSE.
    function automatic wm_state_e next_phase(input wm_state_e  cur,
                                             input logic [1:0] mode_sel,
                                             input logic       second_fill);
        wm_state_e nxt;
        nxt = ST_IDLE;
        case (cur)
            ST_FILL: begin
                if (second_fill) begin
                    nxt = ST_RINSE;
                end else begin
                    case (mode_sel)
                        MODE_FULL: nxt = ST_SOAK;
                        MODE_WASH: nxt = ST_WASH;
                        default:   nxt = ST_RINSE;
                    endcase
                end
            end
            ST_SOAK:  nxt = ST_WASH;
            ST_WASH:  nxt = ST_FILL;
            ST_RINSE: nxt = ST_SPIN;
            ST_SPIN:  nxt = ST_DONE;
            default:  nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wm_tick_prescaler.sv
// Divides the main clock into timer ticks; clear restarts the count at 0,
// hold freezes it and suppresses the tick.
module wm_tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign tick      = w_at_last && !hold && !clear;

    // Prescaler counter: 0..TICK_DIV-1, wrapping after the tick.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (hold) begin
            r_count <= r_count;
        end else if (w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + PW'(1);
        end
    end

endmodule

// File: rtl/wm_phase_sequencer.sv
// Washing-machine phase sequencer: walks FILL/SOAK/WASH/RINSE/SPIN for the
// latched programme, with lid pause and cancel abort.
module wm_phase_sequencer
    import wm_pkg::*;
#(
    parameter int TICK_DIV    = 4,
    parameter int CNT_W       = 8,
    parameter int FILL_TICKS  = 3,
    parameter int SOAK_TICKS  = 6,
    parameter int WASH_TICKS  = 10,
    parameter int RINSE_TICKS = 5,
    parameter int SPIN_TICKS  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             lid,
    input  logic             cancel,
    output logic             busy,
    output logic [2:0]       phase,
    output logic             water_Intake,
    output logic             soak_Operation,
    output logic             wash_Operation,
    output logic             rinse_Operation,
    output logic             spin_Operation,
    output logic             paused,
    output logic [CNT_W-1:0] remaining,
    output logic             done,
    output logic             aborted
);

    wm_state_e        r_state, w_state_next, w_after;
    logic [CNT_W-1:0] r_remaining, w_remaining_next;
    logic [1:0]       r_mode, w_mode_next;
    logic             r_second_fill, w_second_fill_next;
    logic             r_aborted, w_aborted_next;
    logic             w_active, w_paused, w_tick, w_start_ok;

    function automatic logic [CNT_W-1:0] phase_ticks(input wm_state_e s);
        logic [CNT_W-1:0] t;
        case (s)
            ST_FILL:  t = CNT_W'(FILL_TICKS);
            ST_SOAK:  t = CNT_W'(SOAK_TICKS);
            ST_WASH:  t = CNT_W'(WASH_TICKS);
            ST_RINSE: t = CNT_W'(RINSE_TICKS);
            ST_SPIN:  t = CNT_W'(SPIN_TICKS);
            default:  t = '0;
        endcase
        return t;
    endfunction

    assign w_active   = (r_state == ST_FILL) || (r_state == ST_SOAK) || (r_state == ST_WASH) ||
                        (r_state == ST_RINSE) || (r_state == ST_SPIN);
    assign w_paused   = w_active && lid;
    assign w_start_ok = start && (mode != MODE_NONE) && !lid && !cancel;
    assign w_after    = next_phase(r_state, r_mode, r_second_fill);

    wm_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (!w_active),
        .hold  (w_paused),
        .tick  (w_tick)
    );

    // Next-state logic: cancel has priority over pause and phase completion.
    always_comb begin
        w_state_next       = r_state;
        w_remaining_next   = r_remaining;
        w_mode_next        = r_mode;
        w_second_fill_next = r_second_fill;
        w_aborted_next     = 1'b0;
        if ((r_state != ST_IDLE) && cancel) begin
            w_state_next       = ST_IDLE;
            w_remaining_next   = '0;
            w_second_fill_next = 1'b0;
            w_aborted_next     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        w_state_next       = ST_FILL;
                        w_remaining_next   = phase_ticks(ST_FILL);
                        w_mode_next        = mode;
                        w_second_fill_next = 1'b0;
                    end else begin
                        w_remaining_next = '0;
                    end
                end
                ST_FILL, ST_SOAK, ST_WASH, ST_RINSE, ST_SPIN: begin
                    if (w_tick && (r_remaining == CNT_W'(1))) begin
                        w_state_next     = w_after;
                        w_remaining_next = phase_ticks(w_after);
                        if (r_state == ST_WASH) begin
                            w_second_fill_next = 1'b1;
                        end else begin
                            w_second_fill_next = r_second_fill;
                        end
                    end else if (w_tick) begin
                        w_remaining_next = r_remaining - CNT_W'(1);
                    end else begin
                        w_remaining_next = r_remaining;
                    end
                end
                ST_DONE: begin
                    w_state_next       = ST_IDLE;
                    w_remaining_next   = '0;
                    w_second_fill_next = 1'b0;
                end
                default: begin
                    w_state_next     = ST_IDLE;
                    w_remaining_next = '0;
                end
            endcase
        end
    end

    // Sequencer state register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_mode        <= MODE_NONE;
            r_second_fill <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_remaining   <= w_remaining_next;
            r_mode        <= w_mode_next;
            r_second_fill <= w_second_fill_next;
            r_aborted     <= w_aborted_next;
        end
    end

    // Phase drives: one per active phase, all low while paused.
    always_comb begin
        water_Intake    = 1'b0;
        soak_Operation  = 1'b0;
        wash_Operation  = 1'b0;
        rinse_Operation = 1'b0;
        spin_Operation  = 1'b0;
        if (!w_paused) begin
            case (r_state)
                ST_FILL:  water_Intake    = 1'b1;
                ST_SOAK:  soak_Operation  = 1'b1;
                ST_WASH:  wash_Operation  = 1'b1;
                ST_RINSE: rinse_Operation = 1'b1;
                ST_SPIN:  spin_Operation  = 1'b1;
                default:  water_Intake    = 1'b0;
            endcase
        end else begin
            water_Intake = 1'b0;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign phase     = r_state;
    assign paused    = w_paused;
    assign remaining = r_remaining;
    assign done      = (r_state == ST_DONE);
    assign aborted   = r_aborted;

endmodule
